// File: rtl/mem_preload_sequencer_pkg.sv
// rtl/mem_preload_sequencer_pkg.sv - shared state encoding and constants for the preload sequencer
//
// Holds the sequencer FSM state type, the fixed slave access size and the
// slave channel indices used by mem_preload_sequencer.
package mem_preload_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WR,
    START,
    RUN,
    RD_REQ,
    RD_WAIT,
    EMIT
  } seq_state_t;

  // Every slave access is a single byte.
  localparam logic [7:0] ACCESS_SIZE = 8'd8;

  // Only channel 0 of the two-channel slave port carries traffic.
  localparam int CH0 = 0;
  localparam int CH1 = 1;

endpackage

// File: rtl/mem_preload_sequencer_addr_ctr.sv
// rtl/mem_preload_sequencer_addr_ctr.sv - loadable wrapping address counter with terminal-count flag
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-low reset
//   load, load_val    restart the transfer count at load_val
//   inc               advance by one transfer
//   limit             number of transfers in the current phase
//   addr              ADDR_W-bit slave address, wraps modulo 2^ADDR_W
//   term_cnt          high while the current transfer is the last one
module preload_addr_ctr
  import mem_preload_sequencer_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_val,
  input  logic              inc,
  input  logic [CNT_W-1:0]  limit,
  output logic [ADDR_W-1:0] addr,
  output logic              term_cnt
);

  // The full-width transfer count lets a phase be longer than the address
  // space; the address is simply its low bits, so it wraps on its own.
  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign addr     = count[ADDR_W-1:0];
  assign term_cnt = ((count + CNT_W'(1)) == limit);

endmodule

// File: rtl/mem_preload_sequencer.sv
// rtl/mem_preload_sequencer.sv - preloads kernel memory, runs the kernel, streams the result back
//
// Optional feature macro: CYCLE_TIMEOUT_EN (watchdog on RUN and RD_WAIT).
//
// Ports:
//   clock, reset                      rising-edge clock, synchronous active-low reset
//   go                                one-cycle request to start a sequence (IDLE only)
//   in_valid/in_ready/in_data         preload byte stream
//   S_oe_ram/S_we_ram                 slave read/write strobes, channel 0 only
//   S_addr_ram/S_Wdata_ram            slave address and write data, channel 0 in low bits
//   S_data_ram_size                   8 while a strobe is active, else 0
//   Sout_Rdata_ram/Sout_DataRdy       slave read data and ready, channel 0 used
//   start_port/done_port              kernel start pulse and completion
//   out_valid/out_ready/out_data      readback byte stream
//   cycles                            kernel cycles from start pulse to done inclusive
//   busy/timeout                      sequence active; watchdog fired (sticky until go)
module mem_preload_sequencer
  import mem_preload_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int LOAD_BYTES  = 64,
  parameter int READ_BYTES  = 64,
  parameter int TIMEOUT_CYC = 200000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  output logic [1:0]          S_oe_ram,
  output logic [1:0]          S_we_ram,
  output logic [2*ADDR_W-1:0] S_addr_ram,
  output logic [15:0]         S_Wdata_ram,
  output logic [7:0]          S_data_ram_size,
  input  logic [15:0]         Sout_Rdata_ram,
  input  logic [1:0]          Sout_DataRdy,
  output logic                start_port,
  input  logic                done_port,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic [31:0]         cycles,
  output logic                busy,
  output logic                timeout
);

  seq_state_t        state;
  logic              we_q;
  logic              oe_q;
  logic [7:0]        wdata_q;
  logic              ctr_load;
  logic              ctr_inc;
  logic [31:0]       ctr_limit;
  logic [ADDR_W-1:0] addr;
  logic              term_cnt;

  // One counter serves both phases: cleared on go and again on done.
  assign ctr_load  = ((state == IDLE) && go) || ((state == RUN) && done_port);
  assign ctr_inc   = (state == WR) || ((state == EMIT) && out_ready);
  assign ctr_limit = ((state == LOAD) || (state == WR)) ? 32'(LOAD_BYTES) : 32'(READ_BYTES);

  preload_addr_ctr #(
    .ADDR_W (ADDR_W),
    .CNT_W  (32)
  ) u_addr_ctr (
    .clock    (clock),
    .reset    (reset),
    .load     (ctr_load),
    .load_val ('0),
    .inc      (ctr_inc),
    .limit    (ctr_limit),
    .addr     (addr),
    .term_cnt (term_cnt)
  );

`ifdef CYCLE_TIMEOUT_EN
  logic        timeout_q;
  logic [31:0] wait_cnt;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Strobes and start_port are one-cycle pulses: cleared by default each
  // cycle and set only on the transition into the state that owns them.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      we_q       <= 1'b0;
      oe_q       <= 1'b0;
      start_port <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= 8'd0;
      wdata_q    <= 8'd0;
      cycles     <= 32'd0;
`ifdef CYCLE_TIMEOUT_EN
      timeout_q  <= 1'b0;
      wait_cnt   <= 32'd0;
`endif
    end else begin
      we_q       <= 1'b0;
      oe_q       <= 1'b0;
      start_port <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            cycles   <= 32'd0;
`ifdef CYCLE_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (in_valid) begin
            wdata_q  <= in_data;
            in_ready <= 1'b0;
            we_q     <= 1'b1;
            state    <= WR;
          end
        end
        WR: begin
          if (term_cnt) begin
            start_port <= 1'b1;
            state      <= START;
          end else begin
            in_ready <= 1'b1;
            state    <= LOAD;
          end
        end
        START: begin
          // The start cycle itself is the first counted cycle; done_port
          // is not looked at here.
          cycles <= 32'd1;
          state  <= RUN;
        end
        RUN: begin
          if (cycles != 32'hFFFF_FFFF) begin
            cycles <= cycles + 32'd1;
          end
          if (done_port) begin
            oe_q  <= 1'b1;
            state <= RD_REQ;
          end
`ifdef CYCLE_TIMEOUT_EN
          else if (cycles >= 32'(TIMEOUT_CYC)) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end
`endif
        end
        RD_REQ: begin
          state <= RD_WAIT;
`ifdef CYCLE_TIMEOUT_EN
          wait_cnt <= 32'd0;
`endif
        end
        RD_WAIT: begin
          if (Sout_DataRdy[CH0]) begin
            out_data  <= Sout_Rdata_ram[7:0];
            out_valid <= 1'b1;
            state     <= EMIT;
          end
`ifdef CYCLE_TIMEOUT_EN
          else if (wait_cnt >= 32'(TIMEOUT_CYC)) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
`endif
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (term_cnt) begin
              state <= IDLE;
            end else begin
              oe_q  <= 1'b1;
              state <= RD_REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    S_we_ram      = 2'b00;
    S_oe_ram      = 2'b00;
    S_we_ram[CH0] = we_q;
    S_oe_ram[CH0] = oe_q;
  end

  assign S_addr_ram      = {{ADDR_W{1'b0}}, addr};
  assign S_Wdata_ram     = {8'h00, wdata_q};
  assign S_data_ram_size = (we_q || oe_q) ? ACCESS_SIZE : 8'd0;
  assign busy            = (state != IDLE);

  // Channel 1 inputs and the watchdog limit are intentionally unused in
  // some builds.
  logic unused_ok;
  assign unused_ok = &{1'b0, Sout_Rdata_ram[15:8], Sout_DataRdy[CH1], (TIMEOUT_CYC == 0)};

endmodule

// File: tb/tb_mem_preload_sequencer.sv
// tb/tb_mem_preload_sequencer.sv - randomized scoreboard bench for mem_preload_sequencer
module tb_mem_preload_sequencer;

  localparam int ADDR_W     = 3;
  localparam int LOAD_BYTES = 11;
  localparam int READ_BYTES = 9;
  localparam int DEPTH      = 1 << ADDR_W;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                go = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [7:0]          in_data = 8'd0;
  logic [1:0]          S_oe_ram;
  logic [1:0]          S_we_ram;
  logic [2*ADDR_W-1:0] S_addr_ram;
  logic [15:0]         S_Wdata_ram;
  logic [7:0]          S_data_ram_size;
  logic [15:0]         Sout_Rdata_ram = 16'hDEAD;
  logic [1:0]          Sout_DataRdy = 2'b00;
  logic                start_port;
  logic                done_port = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [7:0]          out_data;
  logic [31:0]         cycles;
  logic                busy;
  logic                timeout;

  always #5 clock = ~clock;

  mem_preload_sequencer #(
    .ADDR_W     (ADDR_W),
    .LOAD_BYTES (LOAD_BYTES),
    .READ_BYTES (READ_BYTES)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .go              (go),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .S_oe_ram        (S_oe_ram),
    .S_we_ram        (S_we_ram),
    .S_addr_ram      (S_addr_ram),
    .S_Wdata_ram     (S_Wdata_ram),
    .S_data_ram_size (S_data_ram_size),
    .Sout_Rdata_ram  (Sout_Rdata_ram),
    .Sout_DataRdy    (Sout_DataRdy),
    .start_port      (start_port),
    .done_port       (done_port),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .cycles          (cycles),
    .busy            (busy),
    .timeout         (timeout)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: memory image after the preload, and scoreboard queues.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic [7:0]        ref_mem [DEPTH];
  wr_t               exp_wr[$];
  logic [ADDR_W-1:0] exp_rd_addr[$];
  logic [7:0]        exp_out[$];
  logic [7:0]        in_q[$];

  // Kernel and slave memory model.
  logic [7:0] kmem [DEPTH];
  int         k_lat = 10;
  int         kcd = 0;
  int         rcd = 0;
  logic [7:0] rd_byte = 8'd0;
  bit         start_seen = 1'b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      kmem[i]    = 8'd0;
      ref_mem[i] = 8'd0;
    end
    forever begin
      @(negedge clock);
      done_port      = 1'b0;
      Sout_DataRdy   = 2'b00;
      Sout_Rdata_ram = 16'hDEAD;
      if (!reset) begin
        kcd = 0;
        rcd = 0;
      end else begin
        if (kcd > 0) begin
          kcd--;
          if (kcd == 0) done_port = 1'b1;
        end
        if (rcd > 0) begin
          rcd--;
          if (rcd == 0) begin
            Sout_DataRdy   = 2'b01;
            Sout_Rdata_ram = {8'h5A, rd_byte};
          end
        end
        if (start_port) begin
          kcd        = k_lat;
          start_seen = 1'b1;
        end
        if (S_we_ram[0]) kmem[S_addr_ram[ADDR_W-1:0]] = S_Wdata_ram[7:0];
        if (S_oe_ram[0]) begin
          rd_byte = kmem[S_addr_ram[ADDR_W-1:0]];
          rcd     = $urandom_range(1, 3);
        end
      end
    end
  end

  // Readback consumer with random back-pressure.
  initial begin
    forever begin
      @(posedge clock);
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops expected transactions whenever the DUT presents one.
  bit         prev_we = 1'b0;
  bit         prev_oe = 1'b0;
  bit         prev_start = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_out = 8'd0;

  initial begin
    wr_t w;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_we    = 1'b0;
        prev_oe    = 1'b0;
        prev_start = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (S_we_ram[0]) begin
          check("we_single_cycle", prev_we, 0);
          check("we_ch1_zero", S_we_ram[1], 0);
          check("we_size", S_data_ram_size, 8);
          if (exp_wr.size() == 0) begin
            flag_fail("unexpected_write");
          end else begin
            w = exp_wr.pop_front();
            check("wr_addr", S_addr_ram[ADDR_W-1:0], w.addr);
            check("wr_data", S_Wdata_ram[7:0], w.data);
          end
        end
        if (S_oe_ram[0]) begin
          check("oe_single_cycle", prev_oe, 0);
          check("oe_ch1_zero", S_oe_ram[1], 0);
          check("oe_size", S_data_ram_size, 8);
          if (exp_rd_addr.size() == 0) flag_fail("unexpected_read_strobe");
          else check("rd_addr", S_addr_ram[ADDR_W-1:0], exp_rd_addr.pop_front());
        end
        if (!S_we_ram[0] && !S_oe_ram[0] && busy) check("idle_size", S_data_ram_size, 0);
        if (start_port) begin
          check("start_single_cycle", prev_start, 0);
          check("start_after_writes", exp_wr.size(), 0);
        end
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, prev_out);
        end
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) flag_fail("unexpected_output");
          else check("out_data", out_data, exp_out.pop_front());
        end
        prev_we    = S_we_ram[0];
        prev_oe    = S_oe_ram[0];
        prev_start = start_port;
        prev_stall = out_valid && !out_ready;
        prev_out   = out_data;
      end
    end
  end

  task automatic send_bytes();
    bit ok;
    while (in_q.size() > 0) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clock);
        #1;
      end
      in_valid = 1'b1;
      in_data  = in_q[0];
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
        @(negedge clock);
        if (in_ready) ok = 1'b1;
      end
      if (!ok) begin
        flag_fail("in_ready_timeout");
        in_q.delete();
      end else begin
        @(posedge clock);
        #1;
        void'(in_q.pop_front());
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clock);
      if (!busy) done = 1'b1;
    end
    if (!done) flag_fail("wait_idle_timeout");
  endtask

  task automatic load_expectations();
    logic [7:0] b;
    for (int i = 0; i < LOAD_BYTES; i++) begin
      b = 8'($urandom);
      in_q.push_back(b);
      exp_wr.push_back('{addr: ADDR_W'(i % DEPTH), data: b});
      ref_mem[i % DEPTH] = b;
    end
    for (int j = 0; j < READ_BYTES; j++) begin
      exp_rd_addr.push_back(ADDR_W'(j % DEPTH));
      exp_out.push_back(ref_mem[j % DEPTH]);
    end
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(posedge clock);
    #1 go = 1'b0;
  endtask

  task automatic run_seq(input int lat);
    k_lat = lat;
    load_expectations();
    @(posedge clock);
    #1 pulse_go();
    check("busy_after_go", busy, 1);
    check("cycles_cleared", cycles, 0);
    fork
      send_bytes();
      begin
        repeat (4) @(posedge clock);
        #1 pulse_go();
      end
    join
    wait_idle(3000);
    check("cycles", cycles, 64'(lat + 1));
    check("timeout_low", timeout, 0);
    check("writes_drained", exp_wr.size(), 0);
    check("reads_drained", exp_rd_addr.size(), 0);
    check("outputs_drained", exp_out.size(), 0);
    repeat (3) @(posedge clock);
    #1;
    check("cycles_held", cycles, 64'(lat + 1));
    check("busy_idle", busy, 0);
  endtask

  task automatic reset_mid_run();
    bit ok = 1'b0;
    k_lat      = 1000;
    start_seen = 1'b0;
    load_expectations();
    @(posedge clock);
    #1 pulse_go();
    send_bytes();
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clock);
      if (start_seen) ok = 1'b1;
    end
    if (!ok) flag_fail("start_timeout");
    repeat (3) @(posedge clock);
    #1;
    check("busy_in_run", busy, 1);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_cycles", cycles, 0);
    check("rst_start", start_port, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_strobes", {S_we_ram, S_oe_ram}, 0);
    exp_rd_addr.delete();
    exp_out.delete();
    reset = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_cycles", cycles, 0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_start", start_port, 0);
    check("reset_strobes", {S_we_ram, S_oe_ram}, 0);
    check("reset_size", S_data_ram_size, 0);
    check("reset_cycles", cycles, 0);
    check("reset_timeout", timeout, 0);
    reset = 1'b1;

    run_seq(10);
    run_seq(1);
    for (int n = 0; n < 4; n++) run_seq($urandom_range(2, 30));
    reset_mid_run();
    run_seq(3);

    check("final_writes_left", exp_wr.size(), 0);
    check("final_outputs_left", exp_out.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench did not complete");
  end

endmodule
